// File: rtl/seg7_scan_if.sv
// Bus between a BCD source and the seg7_scan display driver.
// The master supplies the digit word and scan controls; the slave drives the board pins.
interface seg7_scan_if #(
   parameter int DIGITS = 4
);
   logic                  en;
   logic                  load;
   logic [4*DIGITS-1:0]   bcd_in;
   logic [DIGITS-1:0]     dp_in;
   logic                  blank_lz;
   logic [6:0]            seg;
   logic                  dp;
   logic [DIGITS-1:0]     an;
   logic                  frame;

   modport master (
      output en, load, bcd_in, dp_in, blank_lz,
      input  seg, dp, an, frame
   );

   modport slave (
      input  en, load, bcd_in, dp_in, blank_lz,
      output seg, dp, an, frame
   );
endinterface

// File: rtl/seg7_scan.sv
// Multiplexed 7-segment driver: captures a packed BCD word into a pending
// buffer, promotes it to the display buffer only between frames (or while
// idle) so a frame never mixes two words, and scans one digit every SCAN_DIV
// clocks.  Leading zeros can be blanked; COMMON_ANODE flips pin polarity only.
module seg7_scan #(
   parameter int DIGITS       = 4,
   parameter int SCAN_DIV     = 1000,
   parameter int COMMON_ANODE = 0
) (
   input  logic        clk,
   input  logic        rst,
   seg7_scan_if.slave  bus
);
   localparam int   PW  = $clog2(SCAN_DIV);
   localparam int   IW  = $clog2(DIGITS);
   localparam logic POL = (COMMON_ANODE != 0);

   typedef enum logic {IDLE, SCAN} state_t;

   state_t                state;
   logic [PW-1:0]         presc;
   logic [IW-1:0]         idx;

   logic [4*DIGITS-1:0]   pend_bcd;
   logic [DIGITS-1:0]     pend_dp;
   logic                  pend_valid;
   logic [4*DIGITS-1:0]   disp_bcd;
   logic [DIGITS-1:0]     disp_dp;

   logic                  tick;
   logic                  wrap;
   logic                  xfer;

   logic [DIGITS-1:0]     blank;
   logic [DIGITS-1:0]     an_v;
   logic [3:0]            cur_digit;
   logic                  cur_dp;
   logic                  cur_blank;

   logic [6:0]            seg_p1;
   logic                  dp_p1;
   logic [DIGITS-1:0]     an_p1;
   logic                  frame_p1;

   // BCD to {g,f,e,d,c,b,a}; non-decimal codes show a dash
   function automatic logic [6:0] decode(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'd0:    s = 7'b0111111;
         4'd1:    s = 7'b0000110;
         4'd2:    s = 7'b1011011;
         4'd3:    s = 7'b1001111;
         4'd4:    s = 7'b1100110;
         4'd5:    s = 7'b1101101;
         4'd6:    s = 7'b1111101;
         4'd7:    s = 7'b0000111;
         4'd8:    s = 7'b1111111;
         4'd9:    s = 7'b1101111;
         default: s = 7'b1000000;
      endcase
      return s;
   endfunction

   // tick ends a digit slot; wrap is the tick of the last digit (frame end)
   assign tick = (state == SCAN) && (presc == PW'(SCAN_DIV - 1));
   assign wrap = tick && (idx == IW'(DIGITS - 1));
   // promote pending data only when no frame is in progress
   assign xfer = pend_valid && ((state == IDLE) || wrap);

   // Scan FSM: prescaler and digit index advance only while scanning
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         presc <= '0;
         idx   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.en) begin
                  state <= SCAN;
                  presc <= '0;
                  idx   <= '0;
               end
            end
            SCAN: begin
               if (!bus.en) begin
                  state <= IDLE;
                  presc <= '0;
                  idx   <= '0;
               end else if (tick) begin
                  presc <= '0;
                  idx   <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
               end else begin
                  presc <= presc + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Double buffer: a load and a promotion on the same edge keep valid set
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_bcd   <= '0;
         pend_dp    <= '0;
         pend_valid <= 1'b0;
         disp_bcd   <= '0;
         disp_dp    <= '0;
      end else begin
         if (xfer) begin
            disp_bcd <= pend_bcd;
            disp_dp  <= pend_dp;
         end
         if (bus.load) begin
            pend_bcd <= bus.bcd_in;
            pend_dp  <= bus.dp_in;
         end
         pend_valid <= bus.load | (pend_valid & ~xfer);
      end
   end

   // Leading-zero mask: blank from the MSB down until a nonzero value or a lit dp
   always_comb begin
      logic lead;
      blank = '0;
      lead  = bus.blank_lz;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         if ((disp_bcd[4*i +: 4] != 4'd0) || disp_dp[i]) lead = 1'b0;
         blank[i] = lead;
      end
   end

   // Select the active digit's data and its one-hot anode
   always_comb begin
      an_v       = '0;
      an_v[idx]  = 1'b1;
      cur_digit  = disp_bcd[{idx, 2'b00} +: 4];
      cur_dp     = disp_dp[idx];
      cur_blank  = blank[idx];
   end

   // Pin register: polarity applied here only, dark whenever not scanning
   always_ff @(posedge clk) begin
      if (rst) begin
         seg_p1   <= {7{POL}};
         dp_p1    <= POL;
         an_p1    <= {DIGITS{POL}};
         frame_p1 <= 1'b0;
      end else begin
         frame_p1 <= wrap;
         if (state == SCAN) begin
            seg_p1 <= (cur_blank ? 7'd0 : decode(cur_digit)) ^ {7{POL}};
            dp_p1  <= (cur_blank ? 1'b0 : cur_dp) ^ POL;
            an_p1  <= an_v ^ {DIGITS{POL}};
         end else begin
            seg_p1 <= {7{POL}};
            dp_p1  <= POL;
            an_p1  <= {DIGITS{POL}};
         end
      end
   end

   assign bus.seg   = seg_p1;
   assign bus.dp    = dp_p1;
   assign bus.an    = an_p1;
   assign bus.frame = frame_p1;
endmodule

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan: two instances (common cathode and common anode) share
// one stimulus; a vector table covers decode/blanking, hand sequences cover
// double buffering, enable toggling and mid-scan reset.
module tb_seg7_scan;
   logic clk;
   logic rst;

   int n_chk  = 0;
   int n_fail = 0;

   seg7_scan_if #(.DIGITS(4)) ifc0 ();
   seg7_scan_if #(.DIGITS(4)) ifc1 ();

   seg7_scan #(.DIGITS(4), .SCAN_DIV(4), .COMMON_ANODE(0)) dut0 (
      .clk (clk),
      .rst (rst),
      .bus (ifc0.slave)
   );

   seg7_scan #(.DIGITS(4), .SCAN_DIV(4), .COMMON_ANODE(1)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (ifc1.slave)
   );

   assign ifc1.en       = ifc0.en;
   assign ifc1.load     = ifc0.load;
   assign ifc1.bcd_in   = ifc0.bcd_in;
   assign ifc1.dp_in    = ifc0.dp_in;
   assign ifc1.blank_lz = ifc0.blank_lz;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] bcd;
      logic [3:0]  dpi;
      logic        blz;
      logic [27:0] seg;   // {d3,d2,d1,d0}
      logic [3:0]  dpo;
   } vec_t;

   vec_t vecs[10];

   function automatic logic [6:0] seg_of(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'd0: s = 7'b0111111;  4'd1: s = 7'b0000110;
         4'd2: s = 7'b1011011;  4'd3: s = 7'b1001111;
         4'd4: s = 7'b1100110;  4'd5: s = 7'b1101101;
         4'd6: s = 7'b1111101;  4'd7: s = 7'b0000111;
         4'd8: s = 7'b1111111;  4'd9: s = 7'b1101111;
         default: s = 7'b1000000;
      endcase
      return s;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // dig < 0 means dark (all outputs off)
   task automatic chk_out(input int dig, input logic [6:0] es, input logic ed, input logic ef);
      logic [3:0] ea;
      logic [3:0] ea_n;
      logic [6:0] es_n;
      logic       ed_n;
      ea   = (dig < 0) ? 4'b0000 : 4'(1 << dig);
      ea_n = ~ea;
      es_n = ~es;
      ed_n = ~ed;
      chk("an",       32'(ifc0.an),    32'(ea));
      chk("seg",      32'(ifc0.seg),   32'(es));
      chk("dp",       32'(ifc0.dp),    32'(ed));
      chk("frame",    32'(ifc0.frame), 32'(ef));
      chk("an_ca",    32'(ifc1.an),    32'(ea_n));
      chk("seg_ca",   32'(ifc1.seg),   32'(es_n));
      chk("dp_ca",    32'(ifc1.dp),    32'(ed_n));
      chk("frame_ca", 32'(ifc1.frame), 32'(ef));
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic run_vec(input int v);
      ifc0.en   = 1'b0;
      ifc0.load = 1'b0;
      cyc(3);
      ifc0.bcd_in   = vecs[v].bcd;
      ifc0.dp_in    = vecs[v].dpi;
      ifc0.blank_lz = vecs[v].blz;
      ifc0.load     = 1'b1;
      cyc(1);
      ifc0.load = 1'b0;
      cyc(1);
      chk_out(-1, 7'd0, 1'b0, 1'b0);
      ifc0.en = 1'b1;
      cyc(1);
      chk_out(-1, 7'd0, 1'b0, 1'b0);
      for (int i = 0; i < 32; i++) begin
         int d;
         cyc(1);
         d = (i / 4) % 4;
         chk_out(d, vecs[v].seg[7*d +: 7], vecs[v].dpo[d], (i % 16) == 15);
      end
   endtask

   initial begin
      logic [15:0] words[3];
      rst           = 1'b1;
      ifc0.en       = 1'b0;
      ifc0.load     = 1'b0;
      ifc0.bcd_in   = '0;
      ifc0.dp_in    = '0;
      ifc0.blank_lz = 1'b0;

      vecs[0] = '{16'h1234, 4'b0000, 1'b0, {7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110}, 4'b0000};
      vecs[1] = '{16'h0050, 4'b0000, 1'b1, {7'b0000000, 7'b0000000, 7'b1101101, 7'b0111111}, 4'b0000};
      vecs[2] = '{16'h0000, 4'b0000, 1'b1, {7'b0000000, 7'b0000000, 7'b0000000, 7'b0111111}, 4'b0000};
      vecs[3] = '{16'h00A0, 4'b0000, 1'b1, {7'b0000000, 7'b0000000, 7'b1000000, 7'b0111111}, 4'b0000};
      vecs[4] = '{16'h0050, 4'b0000, 1'b0, {7'b0111111, 7'b0111111, 7'b1101101, 7'b0111111}, 4'b0000};
      vecs[5] = '{16'h0203, 4'b0100, 1'b1, {7'b0000000, 7'b1011011, 7'b0111111, 7'b1001111}, 4'b0100};
      vecs[6] = '{16'h0000, 4'b1000, 1'b1, {7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111}, 4'b1000};
      vecs[7] = '{16'hFEDC, 4'b0000, 1'b0, {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000}, 4'b0000};
      vecs[8] = '{16'h9876, 4'b0000, 1'b0, {7'b1101111, 7'b1111111, 7'b0000111, 7'b1111101}, 4'b0000};
      vecs[9] = '{16'h0008, 4'b0000, 1'b1, {7'b0000000, 7'b0000000, 7'b0000000, 7'b1111111}, 4'b0000};

      // reset state
      cyc(2);
      chk_out(-1, 7'd0, 1'b0, 1'b0);
      rst = 1'b0;

      for (int v = 0; v < 10; v++) run_vec(v);

      // double buffering: load mid-frame, then load on the wrap edge
      words[0] = 16'h1234;
      words[1] = 16'h5678;
      words[2] = 16'h9999;
      ifc0.en       = 1'b0;
      ifc0.blank_lz = 1'b0;
      ifc0.dp_in    = '0;
      cyc(3);
      ifc0.bcd_in = words[0];
      ifc0.load   = 1'b1;
      cyc(1);
      ifc0.load = 1'b0;
      cyc(1);
      ifc0.en = 1'b1;
      cyc(1);
      for (int i = 0; i < 48; i++) begin
         int d;
         logic [15:0] w;
         if (i == 5) begin
            ifc0.bcd_in = words[1];
            ifc0.load   = 1'b1;
         end else if (i == 15) begin
            ifc0.bcd_in = words[2];
            ifc0.load   = 1'b1;
         end else begin
            ifc0.load = 1'b0;
         end
         cyc(1);
         d = (i / 4) % 4;
         w = words[i / 16];
         chk_out(d, seg_of(w[4*d +: 4]), 1'b0, (i % 16) == 15);
      end
      ifc0.load = 1'b0;

      // enable drop mid-frame, then re-enable restarts at digit 0
      for (int i = 0; i < 7; i++) begin
         cyc(1);
         chk_out(i / 4, 7'b1101111, 1'b0, 1'b0);
      end
      ifc0.en = 1'b0;
      cyc(1);
      chk_out(1, 7'b1101111, 1'b0, 1'b0);
      cyc(1);
      chk_out(-1, 7'd0, 1'b0, 1'b0);
      cyc(1);
      chk_out(-1, 7'd0, 1'b0, 1'b0);
      ifc0.en = 1'b1;
      cyc(1);
      chk_out(-1, 7'd0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         cyc(1);
         chk_out(i / 4, 7'b1101111, 1'b0, 1'b0);
      end

      // reset mid-scan beats a simultaneous load; display comes back as zero
      rst           = 1'b1;
      ifc0.load     = 1'b1;
      ifc0.bcd_in   = 16'h1111;
      cyc(1);
      chk_out(-1, 7'd0, 1'b0, 1'b0);
      rst       = 1'b0;
      ifc0.load = 1'b0;
      cyc(1);
      chk_out(-1, 7'd0, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         cyc(1);
         chk_out(i / 4, 7'b0111111, 1'b0, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
